axi_large_ro_lite_slave: RTL and testbench

//  AXI4-Lite responder for the large ring-oscillator peripheral; the slave end of the PS/VIP master's 4-register traffic.

---
 rtl/axi_large_ro_pkg.sv | 37 +++
 rtl/axi_large_ro_regfile.sv | 37 +++
 rtl/axi_large_ro_lite_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_large_ro_lite_slave.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_large_ro_pkg.sv
// Shared types and register map for the large ring-oscillator AXI4-Lite slave.
package axi_large_ro_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int IDX_W  = ADDR_W - 2;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Word indices (byte address >> 2)
    localparam logic [IDX_W-1:0] REG_CTRL    = 3'd0;
    localparam logic [IDX_W-1:0] REG_SEL     = 3'd1;
    localparam logic [IDX_W-1:0] REG_WIN     = 3'd2;
    localparam logic [IDX_W-1:0] REG_SCRATCH = 3'd3;
    localparam logic [IDX_W-1:0] REG_CNT     = 3'd4;

    // True for indices backed by the RW register file
    function automatic logic idx_is_reg(logic [IDX_W-1:0] idx);
        return idx < REG_CNT;
    endfunction

endpackage

// File: rtl/axi_large_ro_regfile.sv
// Byte-strobed RW register storage: one write port, one asynchronous read port,
// plus the full array exposed for the control outputs.
module axi_large_ro_regfile
    import axi_large_ro_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DW       = 32,
    parameter int RIW      = $clog2(NUM_REGS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           we_i,
    input  logic [RIW-1:0]                 widx_i,
    input  logic [DW-1:0]                  wdata_i,
    input  logic [DW/8-1:0]                wstrb_i,
    input  logic [RIW-1:0]                 ridx_i,
    output logic [DW-1:0]                  rdata_o,
    output logic [NUM_REGS-1:0][DW-1:0]    regs_o
);

    logic [NUM_REGS-1:0][DW-1:0] regs_q;

    // Storage update: only the strobed byte lanes of the addressed word change
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '0;
        end else if (we_i) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wstrb_i[b]) regs_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = regs_q[ridx_i];
    assign regs_o  = regs_q;

endmodule

// File: rtl/axi_large_ro_lite_slave.sv
// AXI4-Lite slave for the large RO peripheral: four RW control registers,
// independent write/read FSMs, address decode with SLVERR for unmapped words.
// Optional macro AXI_RO_CNT_EN maps ro_count_i read-only at 0x10.
module axi_large_ro_lite_slave
    import axi_large_ro_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            ro_enable_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ro_select_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ro_window_o,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   ro_count_i
);

    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int RIW = $clog2(NUM_REGS);

    // Write channel state
    wr_state_t          wst_q;
    logic               awready_q, wready_q, bvalid_q;
    resp_t              bresp_q;
    logic [AW-1:0]      awaddr_q;
    logic [DW-1:0]      wdata_q;
    logic [DW/8-1:0]    wstrb_q;

    // Read channel state
    rd_state_t          rdst_q;
    logic               arready_q, rvalid_q;
    resp_t              rresp_q;
    logic [DW-1:0]      rdata_q;

    logic               aw_hs, w_hs, ar_hs;
    logic               wr_fire, wr_ok;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [DW/8-1:0]    wr_strb;
    logic [AW-3:0]      wr_idx, rd_idx;
    logic [DW-1:0]      rf_rdata, rd_data_d;
    resp_t              rd_resp_d;
    logic [NUM_REGS-1:0][DW-1:0] rf_regs;

    assign aw_hs  = S_AXI_AWVALID & awready_q;
    assign w_hs   = S_AXI_WVALID & wready_q;
    assign ar_hs  = S_AXI_ARVALID & arready_q;
    assign wr_idx = wr_addr[AW-1:2];
    assign wr_ok  = idx_is_reg(wr_idx);
    assign rd_idx = S_AXI_ARADDR[AW-1:2];

    // Commit happens in the cycle the second half arrives; pick each half from
    // its latch if it came earlier, otherwise straight off the bus.
    always_comb begin
        wr_fire = 1'b0;
        case (wst_q)
            W_IDLE:    wr_fire = aw_hs & w_hs;
            W_HAVE_AW: wr_fire = w_hs;
            W_HAVE_W:  wr_fire = aw_hs;
            default:   wr_fire = 1'b0;
        endcase
        wr_addr = (wst_q == W_HAVE_AW) ? awaddr_q : S_AXI_AWADDR;
        wr_data = (wst_q == W_HAVE_W)  ? wdata_q  : S_AXI_WDATA;
        wr_strb = (wst_q == W_HAVE_W)  ? wstrb_q  : S_AXI_WSTRB;
    end

    axi_large_ro_regfile #(.NUM_REGS(NUM_REGS), .DW(DW)) u_regfile (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .we_i    (wr_fire & wr_ok),
        .widx_i  (wr_idx[RIW-1:0]),
        .wdata_i (wr_data),
        .wstrb_i (wr_strb),
        .ridx_i  (rd_idx[RIW-1:0]),
        .rdata_o (rf_rdata),
        .regs_o  (rf_regs)
    );

    // Write FSM: accept AW and W independently, respond once both are in
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wst_q     <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else if (wr_fire) begin
            wst_q     <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_ok ? OKAY : SLVERR;
        end else begin
            case (wst_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        wst_q     <= W_HAVE_AW;
                        awaddr_q  <= S_AXI_AWADDR;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                    end else if (w_hs) begin
                        wst_q     <= W_HAVE_W;
                        wdata_q   <= S_AXI_WDATA;
                        wstrb_q   <= S_AXI_WSTRB;
                        wready_q  <= 1'b0;
                        awready_q <= 1'b1;
                    end else begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        wst_q     <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read decode; the register file is sampled before any same-cycle write lands
    always_comb begin
        rd_data_d = '0;
        rd_resp_d = SLVERR;
        if (idx_is_reg(rd_idx)) begin
            rd_data_d = rf_rdata;
            rd_resp_d = OKAY;
        end
`ifdef AXI_RO_CNT_EN
        else if (rd_idx == REG_CNT) begin
            rd_data_d = ro_count_i;
            rd_resp_d = OKAY;
        end
`endif
    end

    // Read FSM: capture data on AR accept, hold until RREADY
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdst_q    <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            case (rdst_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdst_q    <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_data_d;
                        rresp_q   <= rd_resp_d;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rdst_q    <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    assign ro_enable_o = rf_regs[REG_CTRL[RIW-1:0]][0];
    assign ro_select_o = rf_regs[REG_SEL[RIW-1:0]];
    assign ro_window_o = rf_regs[REG_WIN[RIW-1:0]];

    // Bits that are intentionally not consumed (prot, byte offset, scratch reg)
    logic unused;
`ifdef AXI_RO_CNT_EN
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0],
                      rf_regs[REG_CTRL[RIW-1:0]][DW-1:1], rf_regs[REG_SCRATCH[RIW-1:0]]};
`else
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0],
                      rf_regs[REG_CTRL[RIW-1:0]][DW-1:1], rf_regs[REG_SCRATCH[RIW-1:0]],
                      ro_count_i};
`endif

endmodule

// File: tb/tb_axi_large_ro_lite_slave.sv
// Directed self-checking bench for axi_large_ro_lite_slave.
module tb_axi_large_ro_lite_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        ro_enable_o;
    logic [31:0] ro_select_o;
    logic [31:0] ro_window_o;
    logic [31:0] ro_count_i;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axi_large_ro_lite_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .ro_enable_o(ro_enable_o), .ro_select_o(ro_select_o),
        .ro_window_o(ro_window_o), .ro_count_i(ro_count_i)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic a, w;
        int n;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        n = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
            a = S_AXI_AWVALID && S_AXI_AWREADY;
            w = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (a) S_AXI_AWVALID = 1'b0;
            if (w) S_AXI_WVALID = 1'b0;
            n++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
        checks++;
        if (S_AXI_BVALID !== 1'b1) begin
            errors++; $display("FAIL write_bvalid addr=%h got %b exp 1", addr, S_AXI_BVALID);
        end
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic a;
        int n;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (S_AXI_ARVALID && n < 20) begin
            a = S_AXI_ARREADY;
            tick();
            if (a) S_AXI_ARVALID = 1'b0;
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin tick(); n++; end
        checks++;
        if (S_AXI_RVALID !== 1'b1) begin
            errors++; $display("FAIL read_rvalid addr=%h got %b exp 1", addr, S_AXI_RVALID);
        end
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1; tick(); S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
        ro_count_i = 32'h0000_1234;
        repeat (3) tick();
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
            errors++; $display("FAIL reset_handshake got %b exp 00000",
                {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
        end
        checks++;
        if ({S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP} !== 36'h0) begin
            errors++; $display("FAIL reset_data got %h/%b/%b exp 0", S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP);
        end
        checks++;
        if ({ro_enable_o, ro_select_o, ro_window_o} !== 65'h0) begin
            errors++; $display("FAIL reset_outputs got %b %h %h exp 0", ro_enable_o, ro_select_o, ro_window_o);
        end
        ARESET = 1'b0;
        tick();
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            errors++; $display("FAIL post_reset_ready got %b exp 111",
                {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
    endtask

    task automatic test_basic();
        logic [1:0]  r;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), 32'(i + 1), 4'hF, r);
            checks++;
            if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp idx=%0d got %b exp 00", i, r); end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), d, r);
            checks++;
            if ({d, r} !== {32'(i + 1), 2'b00}) begin
                errors++; $display("FAIL basic_read idx=%0d got %h/%b exp %h/00", i, d, r, i + 1);
            end
        end
        checks++;
        if ({ro_enable_o, ro_select_o, ro_window_o} !== {1'b1, 32'd2, 32'd3}) begin
            errors++; $display("FAIL basic_outputs got %b %h %h exp 1 2 3", ro_enable_o, ro_select_o, ro_window_o);
        end
    endtask

    task automatic test_w_first();
        logic [1:0]  r;
        logic [31:0] d;
        logic        early_b = 1'b0;
        logic        extra_b = 1'b0;
        S_AXI_WDATA = 32'hA5A5_A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        repeat (3) begin
            if (S_AXI_BVALID) early_b = 1'b1;
            tick();
        end
        checks++;
        if ({early_b, S_AXI_WREADY, S_AXI_AWREADY} !== 3'b001) begin
            errors++; $display("FAIL wfirst_wait got early_b=%b wready=%b awready=%b exp 0 0 1",
                early_b, S_AXI_WREADY, S_AXI_AWREADY);
        end
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        checks++;
        if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b100) begin
            errors++; $display("FAIL wfirst_bvalid got %b/%b exp 1/00", S_AXI_BVALID, S_AXI_BRESP);
        end
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
        repeat (3) begin
            if (S_AXI_BVALID) extra_b = 1'b1;
            tick();
        end
        checks++;
        if (extra_b !== 1'b0) begin errors++; $display("FAIL wfirst_single_b got extra=%b exp 0", extra_b); end
        axi_read(5'h08, d, r);
        checks++;
        if ({d, r, ro_window_o} !== {32'hA5A5_A5A5, 2'b00, 32'hA5A5_A5A5}) begin
            errors++; $display("FAIL wfirst_read got %h/%b win=%h exp a5a5a5a5/00", d, r, ro_window_o);
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  r, r2;
        logic [31:0] d;
        axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, r);
        axi_write(5'h04, 32'h0000_0000, 4'b0101, r);
        axi_read(5'h04, d, r2);
        checks++;
        if ({d, r, r2} !== {32'hFF00_FF00, 4'b0000}) begin
            errors++; $display("FAIL strobe_0101 got %h/%b/%b exp ff00ff00/00/00", d, r, r2);
        end
        axi_write(5'h04, 32'h1234_5678, 4'b0000, r);
        axi_read(5'h04, d, r2);
        checks++;
        if ({d, r, ro_select_o} !== {32'hFF00_FF00, 2'b00, 32'hFF00_FF00}) begin
            errors++; $display("FAIL strobe_zero got %h/%b sel=%h exp ff00ff00/00", d, r, ro_select_o);
        end
    endtask

    task automatic test_backpressure();
        logic bad_b = 1'b0;
        logic bad_r = 1'b0;
        S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h0000_0055; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        repeat (5) begin
            if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY} !== 5'b10000) bad_b = 1'b1;
            tick();
        end
        checks++;
        if (bad_b !== 1'b0) begin errors++; $display("FAIL bstall_hold got bad=%b exp 0", bad_b); end
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
        checks++;
        if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL bstall_release got %b exp 0", S_AXI_BVALID); end
        S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        repeat (5) begin
            if ({S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY} !== {1'b1, 32'h55, 2'b00, 1'b0}) bad_r = 1'b1;
            tick();
        end
        checks++;
        if (bad_r !== 1'b0) begin errors++; $display("FAIL rstall_hold got bad=%b exp 0", bad_r); end
        S_AXI_RREADY = 1'b1; tick(); S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_slverr();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(5'h14, 32'hDEAD_BEEF, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL err_write14 got %b exp 10", r); end
        axi_read(5'h14, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b10}) begin errors++; $display("FAIL err_read14 got %h/%b exp 0/10", d, r); end
        axi_write(5'h10, 32'hFFFF_FFFF, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL err_write10 got %b exp 10", r); end
        axi_read(5'h10, d, r);
        checks++;
`ifdef AXI_RO_CNT_EN
        if ({d, r} !== {32'h0000_1234, 2'b00}) begin errors++; $display("FAIL cnt_read10 got %h/%b exp 1234/00", d, r); end
`else
        if ({d, r} !== {32'h0, 2'b10}) begin errors++; $display("FAIL err_read10 got %h/%b exp 0/10", d, r); end
`endif
        axi_read(5'h05, d, r);
        checks++;
        if ({d, r} !== {32'hFF00_FF00, 2'b00}) begin errors++; $display("FAIL unaligned_read got %h/%b exp ff00ff00/00", d, r); end
        checks++;
        if ({ro_enable_o, ro_window_o} !== {1'b1, 32'hA5A5_A5A5}) begin
            errors++; $display("FAIL err_no_effect got %b %h exp 1 a5a5a5a5", ro_enable_o, ro_window_o);
        end
    endtask

    task automatic test_concurrent();
        logic [1:0]  r;
        logic [31:0] d;
        S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h0000_0077; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        checks++;
        if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA} !== {2'b11, 32'h55}) begin
            errors++; $display("FAIL concurrent_prewrite got b=%b r=%b d=%h exp 1 1 55",
                S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA);
        end
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1; tick();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_read(5'h0C, d, r);
        checks++;
        if ({d, r} !== {32'h77, 2'b00}) begin errors++; $display("FAIL concurrent_after got %h/%b exp 77/00", d, r); end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  r;
        logic [31:0] d;
        logic        saw_b = 1'b0;
        S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        repeat (4) begin
            if (S_AXI_BVALID) saw_b = 1'b1;
            tick();
        end
        checks++;
        if (saw_b !== 1'b0) begin errors++; $display("FAIL midreset_no_b got %b exp 0", saw_b); end
        checks++;
        if ({ro_enable_o, ro_select_o, ro_window_o} !== 65'h0) begin
            errors++; $display("FAIL midreset_regs got %b %h %h exp 0", ro_enable_o, ro_select_o, ro_window_o);
        end
        axi_read(5'h0C, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b00}) begin errors++; $display("FAIL midreset_scratch got %h/%b exp 0/00", d, r); end
        axi_write(5'h00, 32'h1, 4'hF, r);
        checks++;
        if ({r, ro_enable_o} !== 3'b001) begin
            errors++; $display("FAIL midreset_recover got %b en=%b exp 00 1", r, ro_enable_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_first();
        test_strobe();
        test_backpressure();
        test_slverr();
        test_concurrent();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
